dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The module SHALL have the parameter MAX_WAIT, default 4, giving the maximum number of arbitration cycles the debug port can lose before it wins.
REQ-002 The module SHALL have these ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held with cpu_we/cpu_a/cpu_wd stable until cpu_gnt
- cpu_we  in  3  access code, same encoding as the data memory WE: 000 lw, 001 sw, 011 sb, 010 lb, 110 lbu
- cpu_a  in  32  byte address
- cpu_wd  in  32  store data
- cpu_gnt  out  1  one-cycle pulse; the CPU access is on the memory this cycle
- cpu_rvalid  out  1  one-cycle pulse the cycle after a CPU load grant
- cpu_rd  out  32  registered load data, valid with cpu_rvalid
- dbg_req, dbg_we[3], dbg_a[32], dbg_wd[32]  in  debug/loader port, same rules as the CPU port
- dbg_gnt, dbg_rvalid, dbg_rd[32]  out  debug port, same rules as the CPU port
- mem_we  out  3  to data memory WE
- mem_a  out  32  to data memory A
- mem_wd  out  32  to data memory WD
- mem_rd  in  32  from data memory RD (asynchronous read)

Function
REQ-003 The FSM SHALL have the states IDLE, ACC_CPU and ACC_DBG, with IDLE as the reset state.
REQ-004 From IDLE, with only one request high, the FSM SHALL go to that port's ACC state on the next edge.
REQ-005 From IDLE, with both requests high, the FSM SHALL go to ACC_DBG if wait_cnt equals MAX_WAIT, and to ACC_CPU otherwise.
REQ-006 From IDLE, with no request high, the FSM SHALL remain in IDLE.
REQ-007 Every ACC state SHALL last exactly one cycle and SHALL always return to IDLE, so each access costs 2 cycles and there are no back-to-back grants.
REQ-008 In each ACC state, the owner's we/a/wd SHALL drive mem_we/mem_a/mem_wd, and the owner's gnt SHALL be high that cycle.
REQ-009 In IDLE, the outputs SHALL be mem_we=000, mem_a=0 and mem_wd=0, which is a harmless read.
REQ-010 In an ACC cycle whose code is lw, lb or lbu, mem_rd SHALL be captured into the owner's rd register, and the owner's rvalid SHALL pulse the next cycle.
REQ-011 A store (001 or 011) SHALL produce no rvalid.
REQ-012 Each rd register SHALL hold its value until the next load for that port.
REQ-013 wait_cnt (width clog2(MAX_WAIT+1)) SHALL increment in any IDLE cycle where dbg_req and cpu_req are both high and the CPU wins, SHALL saturate at MAX_WAIT, and SHALL clear on dbg_gnt.
REQ-014 An unsupported access code SHALL still be granted and passed through unchanged, and SHALL produce no rvalid.
REQ-015 Request inputs sampled in ACC states SHALL be ignored; arbitration happens only in IDLE.

Reset
REQ-016 On a rising edge with rst=1, the module SHALL set: state=IDLE, wait_cnt=0, cpu_gnt=dbg_gnt=0, cpu_rvalid=dbg_rvalid=0, cpu_rd=dbg_rd=0.
REQ-017 While rst=1, mem_we SHALL be forced combinationally to 000, so no store commits even if reset arrives during an ACC state; the interrupted access is dropped without a grant-complete guarantee.

Configuration
REQ-018 With DMEM_ARB_PERF_EN defined, the module SHALL add the outputs cpu_acc_cnt[32], dbg_acc_cnt[32] and conflict_cnt[32]: the first two count grants per port, conflict_cnt counts IDLE cycles with both requests high, all three wrap at 2^32 and reset to 0.
REQ-019 Without DMEM_ARB_PERF_EN, those ports and counters SHALL not exist and behaviour SHALL otherwise be identical.

Structure
REQ-020 The shared package SHALL hold the arb_state_t enum (IDLE, ACC_CPU, ACC_DBG) and the memory access-code constants MEM_LW=3'b000, MEM_SW=3'b001, MEM_SB=3'b011, MEM_LB=3'b010, MEM_LBU=3'b110.
REQ-021 The port-select and load-capture logic SHALL be one sub-module, dmem_arb_port_mux; the FSM and wait counter SHALL live in the top.

Verification
REQ-022 The bench SHALL cover each scenario below against a behavioural model of the data memory:
- CPU sw a=0x100, wd=0xDEADBEEF, then lw a=0x100 -> cpu_gnt at cycles 1 and 3; cpu_rvalid at cycle 4 with cpu_rd=0xDEADBEEF.
- CPU lb at a byte holding 0x80 -> cpu_rd=0xFFFFFF80; lbu at the same address -> cpu_rd=0x00000080.
- cpu_req and dbg_req held high continuously, MAX_WAIT=4 -> grant order CPU,CPU,CPU,CPU,DBG repeating; dbg wait never exceeds 4 arbitrations.
- dbg only: sb a=0x3, wd=0x12 -> mem_we=011 for one cycle; dbg_rvalid never asserted.
- rst asserted during ACC_CPU carrying an sw -> mem_we=000 that cycle, memory unchanged, state IDLE and all outputs 0 next cycle.
- With DMEM_ARB_PERF_EN, 10 contended cycles -> conflict_cnt=5 (IDLE cycles only), and cpu_acc_cnt + dbg_acc_cnt = total grants.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU and debug/loader ports.
package dmem_arbiter_pkg;

   localparam int unsigned WE_W   = 3;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACC_CPU = 2'd1,
      ACC_DBG = 2'd2
   } arb_state_t;

   localparam logic [WE_W-1:0] MEM_LW  = 3'b000;
   localparam logic [WE_W-1:0] MEM_SW  = 3'b001;
   localparam logic [WE_W-1:0] MEM_SB  = 3'b011;
   localparam logic [WE_W-1:0] MEM_LB  = 3'b010;
   localparam logic [WE_W-1:0] MEM_LBU = 3'b110;

   typedef struct packed {
      logic [WE_W-1:0]   we;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] wd;
   } mem_cmd_t;

   function automatic logic is_load(input logic [WE_W-1:0] we);
      return (we == MEM_LW) || (we == MEM_LB) || (we == MEM_LBU);
   endfunction

endpackage

// File: rtl/dmem_arb_port_mux.sv
// Owner selection onto the memory bus and per-port load-data capture.
module dmem_arb_port_mux
   import dmem_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  arb_state_t        state,
   input  arb_state_t        next_state,
   input  logic [WE_W-1:0]   cpu_we,
   input  logic [ADDR_W-1:0] cpu_a,
   input  logic [DATA_W-1:0] cpu_wd,
   input  logic [WE_W-1:0]   dbg_we,
   input  logic [ADDR_W-1:0] dbg_a,
   input  logic [DATA_W-1:0] dbg_wd,
   input  logic [DATA_W-1:0] mem_rd,
   output logic [WE_W-1:0]   mem_we,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wd,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rd,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rd
);

   mem_cmd_t cmd_c;
   mem_cmd_t cmd_q;
   logic     load_c;

   // Command for the cycle being entered; IDLE drives a harmless word read of address 0
   always_comb begin
      cmd_c = '0;
      case (next_state)
         ACC_CPU: begin
            cmd_c.we = cpu_we;
            cmd_c.a  = cpu_a;
            cmd_c.wd = cpu_wd;
         end
         ACC_DBG: begin
            cmd_c.we = dbg_we;
            cmd_c.a  = dbg_a;
            cmd_c.wd = dbg_wd;
         end
         default: cmd_c = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) cmd_q <= '0;
      else     cmd_q <= cmd_c;
   end

   // Reset blocks any store still on the bus, even mid-access
   assign mem_we = rst ? WE_W'(0) : cmd_q.we;
   assign mem_a  = cmd_q.a;
   assign mem_wd = cmd_q.wd;
   assign load_c = is_load(cmd_q.we);

   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rvalid <= 1'b0;
         dbg_rvalid <= 1'b0;
         cpu_rd     <= '0;
         dbg_rd     <= '0;
      end else begin
         cpu_rvalid <= (state == ACC_CPU) && load_c;
         dbg_rvalid <= (state == ACC_DBG) && load_c;
         if ((state == ACC_CPU) && load_c) cpu_rd <= mem_rd;
         if ((state == ACC_DBG) && load_c) dbg_rd <= mem_rd;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU preferred, debug port wins after MAX_WAIT contested losses.
// Optional access/conflict counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic [WE_W-1:0]   cpu_we,
   input  logic [ADDR_W-1:0] cpu_a,
   input  logic [DATA_W-1:0] cpu_wd,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rd,
   input  logic              dbg_req,
   input  logic [WE_W-1:0]   dbg_we,
   input  logic [ADDR_W-1:0] dbg_a,
   input  logic [DATA_W-1:0] dbg_wd,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rd,
   output logic [WE_W-1:0]   mem_we,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [31:0]       cpu_acc_cnt,
   output logic [31:0]       dbg_acc_cnt,
   output logic [31:0]       conflict_cnt
`endif
);

   localparam int unsigned WAIT_W = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   arb_state_t        state;
   arb_state_t        next_state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_nxt;
   logic              both_c;

   assign both_c = cpu_req && dbg_req;

   // Arbitration only in IDLE; every access state falls straight back to IDLE
   always_comb begin
      next_state = state;
      wait_nxt   = wait_cnt;
      case (state)
         IDLE: begin
            if (both_c) begin
               if (wait_cnt == WAIT_MAX) begin
                  next_state = ACC_DBG;
               end else begin
                  next_state = ACC_CPU;
                  wait_nxt   = wait_cnt + WAIT_W'(1);
               end
            end else if (cpu_req) begin
               next_state = ACC_CPU;
            end else if (dbg_req) begin
               next_state = ACC_DBG;
            end
         end
         ACC_CPU: next_state = IDLE;
         ACC_DBG: begin
            next_state = IDLE;
            wait_nxt   = '0;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         cpu_gnt  <= 1'b0;
         dbg_gnt  <= 1'b0;
      end else begin
         state    <= next_state;
         wait_cnt <= wait_nxt;
         cpu_gnt  <= (next_state == ACC_CPU);
         dbg_gnt  <= (next_state == ACC_DBG);
      end
   end

   dmem_arb_port_mux u_mux (
      .clk        (clk),
      .rst        (rst),
      .state      (state),
      .next_state (next_state),
      .cpu_we     (cpu_we),
      .cpu_a      (cpu_a),
      .cpu_wd     (cpu_wd),
      .dbg_we     (dbg_we),
      .dbg_a      (dbg_a),
      .dbg_wd     (dbg_wd),
      .mem_rd     (mem_rd),
      .mem_we     (mem_we),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rd     (cpu_rd),
      .dbg_rvalid (dbg_rvalid),
      .dbg_rd     (dbg_rd)
   );

`ifdef DMEM_ARB_PERF_EN
   // Counters advance on the edge that issues a grant, in step with the gnt pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_acc_cnt  <= '0;
         dbg_acc_cnt  <= '0;
         conflict_cnt <= '0;
      end else begin
         if (next_state == ACC_CPU && state == IDLE) cpu_acc_cnt <= cpu_acc_cnt + 32'd1;
         if (next_state == ACC_DBG && state == IDLE) dbg_acc_cnt <= dbg_acc_cnt + 32'd1;
         if (state == IDLE && both_c)                conflict_cnt <= conflict_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   localparam int unsigned MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, dbg_req;
   logic [2:0]  cpu_we, dbg_we;
   logic [31:0] cpu_a, cpu_wd, dbg_a, dbg_wd;
   logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [31:0] cpu_rd, dbg_rd;
   logic [2:0]  mem_we;
   logic [31:0] mem_a, mem_wd, mem_rd;
`ifdef DMEM_ARB_PERF_EN
   logic [31:0] cpu_acc_cnt, dbg_acc_cnt, conflict_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_a      (cpu_a),
      .cpu_wd     (cpu_wd),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rd     (cpu_rd),
      .dbg_req    (dbg_req),
      .dbg_we     (dbg_we),
      .dbg_a      (dbg_a),
      .dbg_wd     (dbg_wd),
      .dbg_gnt    (dbg_gnt),
      .dbg_rvalid (dbg_rvalid),
      .dbg_rd     (dbg_rd),
      .mem_we     (mem_we),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
`ifdef DMEM_ARB_PERF_EN
      ,
      .cpu_acc_cnt  (cpu_acc_cnt),
      .dbg_acc_cnt  (dbg_acc_cnt),
      .conflict_cnt (conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Data memory device: 1 KiB, little-endian, async read, write on rising edge
   logic [7:0] dmem [1024];
   logic [7:0] shadow [1024];
   logic       dev_clr;
   logic [9:0] dev_b, dev_w;
   assign dev_b = mem_a[9:0];
   assign dev_w = {mem_a[9:2], 2'b00};

   always_comb begin
      case (mem_we)
         MEM_LB:  mem_rd = {{24{dmem[dev_b][7]}}, dmem[dev_b]};
         MEM_LBU: mem_rd = {24'h0, dmem[dev_b]};
         default: mem_rd = {dmem[dev_w + 10'd3], dmem[dev_w + 10'd2], dmem[dev_w + 10'd1], dmem[dev_w]};
      endcase
   end

   always @(posedge clk) begin
      if (dev_clr) begin
         for (int i = 0; i < 1024; i++) dmem[i] <= 8'h00;
      end else if (mem_we == MEM_SW) begin
         dmem[dev_w]         <= mem_wd[7:0];
         dmem[dev_w + 10'd1] <= mem_wd[15:8];
         dmem[dev_w + 10'd2] <= mem_wd[23:16];
         dmem[dev_w + 10'd3] <= mem_wd[31:24];
      end else if (mem_we == MEM_SB) begin
         dmem[dev_b] <= mem_wd[7:0];
      end
   end

   // Reference model state
   logic        exp_cpu_gnt, exp_dbg_gnt, exp_cpu_rvalid, exp_dbg_rvalid;
   logic [31:0] exp_cpu_rd, exp_dbg_rd, exp_mem_a, exp_mem_wd;
   logic [2:0]  exp_mem_we;
   logic [2:0]  g_we;
   logic [31:0] g_a, g_wd;
   int          owner;       // 0: no access in flight, 1: CPU holds memory, 2: debug holds memory
   int          dbg_losses;  // contested arbitrations lost by debug since its last grant
   logic [31:0] n_cpu, n_dbg, n_conf;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [2:0] we, input logic [31:0] a);
      int unsigned b, w;
      b = a & 32'h3FF;
      w = a & 32'h3FC;
      if (we == MEM_LB)  return {{24{shadow[b][7]}}, shadow[b]};
      if (we == MEM_LBU) return {24'h0, shadow[b]};
      return {shadow[w + 3], shadow[w + 2], shadow[w + 1], shadow[w]};
   endfunction

   task automatic ref_store(input logic [2:0] we, input logic [31:0] a, input logic [31:0] wd);
      int unsigned b, w;
      b = a & 32'h3FF;
      w = a & 32'h3FC;
      if (we == MEM_SW) begin
         shadow[w]     = wd[7:0];
         shadow[w + 1] = wd[15:8];
         shadow[w + 2] = wd[23:16];
         shadow[w + 3] = wd[31:24];
      end else if (we == MEM_SB) begin
         shadow[b] = wd[7:0];
      end
   endtask

   // One clock: advance the model with the inputs the DUT samples, then compare all outputs
   task automatic tick();
      logic r, cr, dr;
      logic [2:0] cw, dw;
      logic [31:0] ca, cd, da, dd;
      r = rst; cr = cpu_req; dr = dbg_req;
      cw = cpu_we; ca = cpu_a; cd = cpu_wd;
      dw = dbg_we; da = dbg_a; dd = dbg_wd;
      @(posedge clk);
      exp_cpu_gnt = 1'b0; exp_dbg_gnt = 1'b0;
      exp_cpu_rvalid = 1'b0; exp_dbg_rvalid = 1'b0;
      exp_mem_we = 3'b000; exp_mem_a = 32'h0; exp_mem_wd = 32'h0;
      if (r) begin
         owner = 0; dbg_losses = 0;
         exp_cpu_rd = 32'h0; exp_dbg_rd = 32'h0;
         n_cpu = 32'h0; n_dbg = 32'h0; n_conf = 32'h0;
      end else if (owner != 0) begin
         if (g_we inside {MEM_LW, MEM_LB, MEM_LBU}) begin
            if (owner == 1) begin exp_cpu_rvalid = 1'b1; exp_cpu_rd = ref_load(g_we, g_a); end
            else            begin exp_dbg_rvalid = 1'b1; exp_dbg_rd = ref_load(g_we, g_a); end
         end else begin
            ref_store(g_we, g_a, g_wd);
         end
         owner = 0;
      end else begin
         if (cr && dr) begin
            n_conf = n_conf + 32'd1;
            if (dbg_losses >= MAX_WAIT) owner = 2;
            else begin owner = 1; dbg_losses++; end
         end else if (cr) owner = 1;
         else if (dr)     owner = 2;
         if (owner == 1) begin
            exp_cpu_gnt = 1'b1; n_cpu = n_cpu + 32'd1;
            g_we = cw; g_a = ca; g_wd = cd;
         end else if (owner == 2) begin
            exp_dbg_gnt = 1'b1; n_dbg = n_dbg + 32'd1; dbg_losses = 0;
            g_we = dw; g_a = da; g_wd = dd;
         end
         if (owner != 0) begin exp_mem_we = g_we; exp_mem_a = g_a; exp_mem_wd = g_wd; end
      end
      #1;
      chk("cpu_gnt", 32'(cpu_gnt), 32'(exp_cpu_gnt));
      chk("dbg_gnt", 32'(dbg_gnt), 32'(exp_dbg_gnt));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_cpu_rvalid));
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(exp_dbg_rvalid));
      chk("cpu_rd", cpu_rd, exp_cpu_rd);
      chk("dbg_rd", dbg_rd, exp_dbg_rd);
      chk("mem_we", 32'(mem_we), 32'(rst ? 3'b000 : exp_mem_we));
      chk("mem_a", mem_a, exp_mem_a);
      chk("mem_wd", mem_wd, exp_mem_wd);
`ifdef DMEM_ARB_PERF_EN
      chk("cpu_acc_cnt", cpu_acc_cnt, n_cpu);
      chk("dbg_acc_cnt", dbg_acc_cnt, n_dbg);
      chk("conflict_cnt", conflict_cnt, n_conf);
`endif
   endtask

   task automatic cpu_access(input logic [2:0] we, input logic [31:0] a, input logic [31:0] wd);
      int n;
      cpu_req = 1'b1; cpu_we = we; cpu_a = a; cpu_wd = wd;
      n = 0;
      do begin tick(); n++; end while (!exp_cpu_gnt && n < 16);
      chk("cpu_grant_bound", 32'(cpu_gnt), 32'd1);
      cpu_req = 1'b0;
   endtask

   task automatic dbg_access(input logic [2:0] we, input logic [31:0] a, input logic [31:0] wd);
      int n;
      dbg_req = 1'b1; dbg_we = we; dbg_a = a; dbg_wd = wd;
      n = 0;
      do begin tick(); n++; end while (!exp_dbg_gnt && n < 16);
      chk("dbg_grant_bound", 32'(dbg_gnt), 32'd1);
      dbg_req = 1'b0;
   endtask

   task automatic rand_txn(output logic [2:0] we, output logic [31:0] a, output logic [31:0] wd);
      case ($urandom_range(0, 6))
         0: we = MEM_LW;
         1: we = MEM_SW;
         2: we = MEM_SB;
         3: we = MEM_LB;
         4: we = MEM_LBU;
         5: we = 3'b111;
         default: we = 3'b101;
      endcase
      a  = 32'($urandom_range(0, 1023));
      wd = $urandom;
   endtask

   initial begin
      int g, cpu_wins;
`ifdef DMEM_ARB_PERF_EN
      logic [31:0] conf0;
`endif
      for (int i = 0; i < 1024; i++) shadow[i] = 8'h00;
      owner = 0; dbg_losses = 0;
      rst = 1'b1; dev_clr = 1'b1;
      cpu_req = 1'b0; cpu_we = 3'b000; cpu_a = 32'h0; cpu_wd = 32'h0;
      dbg_req = 1'b0; dbg_we = 3'b000; dbg_a = 32'h0; dbg_wd = 32'h0;
      tick();
      tick();
      chk("reset_rd", cpu_rd | dbg_rd, 32'h0);
      rst = 1'b0; dev_clr = 1'b0;

      // CPU sw then lw at 0x100: grants on cycles 1 and 3, load data on cycle 4
      cpu_req = 1'b1; cpu_we = MEM_SW; cpu_a = 32'h100; cpu_wd = 32'hDEADBEEF;
      tick(); chk("sw_gnt_c1", 32'(cpu_gnt), 32'd1);
      cpu_we = MEM_LW; cpu_wd = 32'h0;
      tick(); chk("lw_idle_c2", 32'(cpu_gnt), 32'd0);
      tick(); chk("lw_gnt_c3", 32'(cpu_gnt), 32'd1);
      cpu_req = 1'b0;
      tick(); chk("lw_rvalid_c4", 32'(cpu_rvalid), 32'd1);
      chk("lw_rd", cpu_rd, 32'hDEADBEEF);

      // Debug byte store: one cycle of sb on the bus, never a read-valid
      dbg_req = 1'b1; dbg_we = MEM_SB; dbg_a = 32'h3; dbg_wd = 32'h12;
      tick(); chk("sb_mem_we", 32'(mem_we), 32'(MEM_SB));
      dbg_req = 1'b0;
      tick(); chk("sb_mem_we_off", 32'(mem_we), 32'd0);
      chk("sb_no_rvalid", 32'(dbg_rvalid), 32'd0);
      tick(); chk("sb_no_rvalid2", 32'(dbg_rvalid), 32'd0);

      // Signed and unsigned byte loads of 0x80
      dbg_access(MEM_SB, 32'h7, 32'h80);
      cpu_access(MEM_LB, 32'h7, 32'h0);
      tick(); chk("lb_sext", cpu_rd, 32'hFFFFFF80);
      cpu_access(MEM_LBU, 32'h7, 32'h0);
      tick(); chk("lbu_zext", cpu_rd, 32'h00000080);

      // Both ports held: grant order CPU x4 then DBG, repeating
      cpu_req = 1'b1; cpu_we = MEM_LW; cpu_a = 32'h100;
      dbg_req = 1'b1; dbg_we = MEM_LW; dbg_a = 32'h7;
      g = 0; cpu_wins = 0;
`ifdef DMEM_ARB_PERF_EN
      conf0 = conflict_cnt;
`endif
      for (int i = 0; i < 30; i++) begin
         tick();
`ifdef DMEM_ARB_PERF_EN
         if (i == 9) chk("conflict_10cyc", conflict_cnt - conf0, 32'd5);
`endif
         if (cpu_gnt || dbg_gnt) begin
            chk("contend_order", 32'(dbg_gnt), 32'((g % 5) == 4));
            g++;
         end
         if (dbg_gnt) cpu_wins = 0;
         if (cpu_gnt) begin
            cpu_wins++;
            chk("dbg_wait_bound", 32'(cpu_wins <= int'(MAX_WAIT)), 32'd1);
         end
      end
      chk("contend_grants", 32'(g), 32'd15);
      cpu_req = 1'b0; dbg_req = 1'b0;
      tick(); tick();

      // Reset arriving during a CPU store drops the store
      cpu_req = 1'b1; cpu_we = MEM_SW; cpu_a = 32'h200; cpu_wd = 32'hCAFEF00D;
      tick(); chk("rst_case_gnt", 32'(cpu_gnt), 32'd1);
      cpu_req = 1'b0; rst = 1'b1;
      #1; chk("rst_mem_we", 32'(mem_we), 32'd0);
      tick();
      chk("rst_no_store", {dmem[515], dmem[514], dmem[513], dmem[512]}, ref_load(MEM_LW, 32'h200));
      chk("rst_gnt_clear", 32'(cpu_gnt), 32'd0);
      rst = 1'b0;
      tick();

      // Random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 79) == 0);
         if (!cpu_req || exp_cpu_gnt) begin
            cpu_req = ($urandom_range(0, 3) != 0);
            rand_txn(cpu_we, cpu_a, cpu_wd);
         end
         if (!dbg_req || exp_dbg_gnt) begin
            dbg_req = ($urandom_range(0, 3) != 0);
            rand_txn(dbg_we, dbg_a, dbg_wd);
         end
         tick();
      end
      rst = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
